// File: rtl/mem_responder.sv
// Word-organised memory target with a programmable wait-state delay, byte-lane
// stores, and misaligned/out-of-range error responses over valid/ready handshakes.
module mem_responder #(
  parameter int          ADDR_WIDTH  = 8,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] MEM_BASE    = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        req_ready,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  input  logic        rsp_ready,
  output logic [1:0]  fsm_state
);

  // Handshake rule on both sides: a transfer happens on a rising edge where
  // valid and ready are both high; valid and its payload hold until then.

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] WAIT   = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;
  localparam logic [1:0] RESP   = 2'd3;

  localparam logic [7:0] WAIT_INIT = 8'(WAIT_CYCLES);

  logic [1:0]            state;
  logic [7:0]            wait_cnt;
  logic [31:0]           cap_addr;
  logic                  cap_write;
  logic [31:0]           cap_wdata;
  logic [3:0]            cap_be;
  logic [31:0]           offset;
  logic [ADDR_WIDTH-1:0] word_idx;
  logic                  acc_err;
  logic [31:0]           mem [2**ADDR_WIDTH];

  assign fsm_state = state;
  assign req_ready = (state == IDLE) && !reset;

  // Out-of-range means the word index has bits set above ADDR_WIDTH.
  assign offset   = cap_addr - MEM_BASE;
  assign word_idx = offset[ADDR_WIDTH+1:2];
  assign acc_err  = (cap_addr[1:0] != 2'b00) || (cap_addr < MEM_BASE) ||
                    ((offset >> (ADDR_WIDTH + 2)) != 32'd0);

  // Storage is not reset; an async reset leaves ACCESS before any edge can write.
  always_ff @(posedge clk) begin
    if (state == ACCESS && cap_write && !acc_err) begin
      for (int i = 0; i < 4; i++) begin
        if (cap_be[i]) mem[word_idx][8*i +: 8] <= cap_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      wait_cnt  <= 8'd0;
      cap_addr  <= 32'd0;
      cap_write <= 1'b0;
      cap_wdata <= 32'd0;
      cap_be    <= 4'd0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            cap_addr  <= req_addr;
            cap_write <= req_write;
            cap_wdata <= req_wdata;
            cap_be    <= req_be;
            wait_cnt  <= WAIT_INIT;
            state     <= (WAIT_CYCLES == 0) ? ACCESS : WAIT;
          end
        end
        WAIT: begin
          wait_cnt <= wait_cnt - 8'd1;
          if (wait_cnt == 8'd1) state <= ACCESS;
        end
        ACCESS: begin
          rsp_valid <= 1'b1;
          rsp_err   <= acc_err;
          rsp_rdata <= (!acc_err && !cap_write) ? mem[word_idx] : 32'd0;
          state     <= RESP;
        end
        default: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
            state     <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: one instance with two wait states and one
// with none, checked against hand-computed data, error flags and latencies.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        reset;

  logic        req_valid, req_write, req_ready;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid, rsp_err, rsp_ready;
  logic [31:0] rsp_rdata;
  logic [1:0]  fsm_state;

  logic        valid0, write0, ready0;
  logic [31:0] addr0, wdata0;
  logic [3:0]  be0;
  logic        rv0, err0, rsp_ready0;
  logic [31:0] rdata0;
  logic [1:0]  state0;

  int checks   = 0;
  int failures = 0;

  mem_responder #(.ADDR_WIDTH(8), .WAIT_CYCLES(2), .MEM_BASE(32'h0)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_be(req_be), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .rsp_ready(rsp_ready), .fsm_state(fsm_state)
  );

  mem_responder #(.ADDR_WIDTH(8), .WAIT_CYCLES(0), .MEM_BASE(32'h0)) dut0 (
    .clk(clk), .reset(reset),
    .req_valid(valid0), .req_write(write0), .req_addr(addr0),
    .req_wdata(wdata0), .req_be(be0), .req_ready(ready0),
    .rsp_valid(rv0), .rsp_rdata(rdata0), .rsp_err(err0),
    .rsp_ready(rsp_ready0), .fsm_state(state0)
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got=timeout exp=finish");
    $fatal(1);
  end

  // Driver: called at a negedge; returns at a negedge with the response
  // sampled and, when rsp_ready is high, the handshake already completed.
  task automatic do_req(input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be,
                        output logic [31:0] rdata, output logic err,
                        output int lat);
    int k;
    req_valid = 1'b1; req_write = wr; req_addr = addr;
    req_wdata = wdata; req_be = be;
    k = 0;
    while (!req_ready && k < 50) begin @(negedge clk); k++; end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    k = 0;
    while (!rsp_valid && k < 50) begin @(negedge clk); k++; end
    lat   = k;
    rdata = rsp_rdata;
    err   = rsp_err;
    if (rsp_ready) @(negedge clk);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
    rsp_ready = 1'b1;
    valid0 = 1'b0; write0 = 1'b0; addr0 = '0; wdata0 = '0; be0 = '0;
    rsp_ready0 = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL reset_req_ready got=%b exp=0", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
    checks++; if (rsp_rdata !== 32'h0) begin failures++; $display("FAIL reset_rsp_rdata got=%h exp=0", rsp_rdata); end
    checks++; if (rsp_err !== 1'b0) begin failures++; $display("FAIL reset_rsp_err got=%b exp=0", rsp_err); end
    checks++; if (fsm_state !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", fsm_state); end
    checks++; if (ready0 !== 1'b0) begin failures++; $display("FAIL reset_ready0 got=%b exp=0", ready0); end
    reset = 1'b0;
    #1;
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL post_reset_req_ready got=%b exp=1", req_ready); end
    @(negedge clk);
  endtask

  task automatic test_store_load;
    logic [31:0] d; logic e; int lat;
    do_req(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, d, e, lat);
    checks++; if (lat !== 3) begin failures++; $display("FAIL store_latency got=%0d exp=3", lat); end
    checks++; if (e !== 1'b0) begin failures++; $display("FAIL store_err got=%b exp=0", e); end
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL store_rdata got=%h exp=00000000", d); end
    do_req(1'b0, 32'h10, 32'h0, 4'h0, d, e, lat);
    checks++; if (lat !== 3) begin failures++; $display("FAIL load_latency got=%0d exp=3", lat); end
    checks++; if (e !== 1'b0) begin failures++; $display("FAIL load_err got=%b exp=0", e); end
    checks++; if (d !== 32'hDEADBEEF) begin failures++; $display("FAIL load_rdata got=%h exp=deadbeef", d); end
  endtask

  task automatic test_byte_lanes;
    logic [31:0] d; logic e; int lat;
    do_req(1'b1, 32'h20, 32'h11223344, 4'hF, d, e, lat);
    do_req(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, d, e, lat);
    do_req(1'b0, 32'h20, 32'h0, 4'h0, d, e, lat);
    checks++; if (d !== 32'h11BB33DD) begin failures++; $display("FAIL lanes_rdata got=%h exp=11bb33dd", d); end
    do_req(1'b1, 32'h20, 32'hFFFFFFFF, 4'b0000, d, e, lat);
    checks++; if (e !== 1'b0) begin failures++; $display("FAIL be0_err got=%b exp=0", e); end
    do_req(1'b0, 32'h20, 32'h0, 4'h0, d, e, lat);
    checks++; if (d !== 32'h11BB33DD) begin failures++; $display("FAIL be0_rdata got=%h exp=11bb33dd", d); end
  endtask

  task automatic test_errors;
    logic [31:0] d; logic e; int lat;
    do_req(1'b1, 32'h0, 32'h12345678, 4'hF, d, e, lat);
    do_req(1'b0, 32'h13, 32'h0, 4'h0, d, e, lat);
    checks++; if (e !== 1'b1) begin failures++; $display("FAIL misaligned_err got=%b exp=1", e); end
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL misaligned_rdata got=%h exp=00000000", d); end
    do_req(1'b1, 32'h400, 32'hFFFFFFFF, 4'hF, d, e, lat);
    checks++; if (e !== 1'b1) begin failures++; $display("FAIL range_err got=%b exp=1", e); end
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL range_rdata got=%h exp=00000000", d); end
    do_req(1'b0, 32'h3FC, 32'h0, 4'h0, d, e, lat);
    checks++; if (e !== 1'b0) begin failures++; $display("FAIL last_word_err got=%b exp=0", e); end
    do_req(1'b0, 32'h0, 32'h0, 4'h0, d, e, lat);
    checks++; if (e !== 1'b0) begin failures++; $display("FAIL word0_err got=%b exp=0", e); end
    checks++; if (d !== 32'h12345678) begin failures++; $display("FAIL word0_rdata got=%h exp=12345678", d); end
  endtask

  task automatic test_backpressure;
    int k;
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h10; req_wdata = '0; req_be = '0;
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL bp_idle_ready got=%b exp=1", req_ready); end
    @(posedge clk);
    @(negedge clk);
    req_addr = 32'h20;
    k = 0;
    while (!rsp_valid && k < 50) begin
      checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL bp_wait_ready got=%b exp=0", req_ready); end
      @(negedge clk); k++;
    end
    checks++; if (k !== 3) begin failures++; $display("FAIL bp_latency got=%0d exp=3", k); end
    for (int i = 0; i < 5; i++) begin
      checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL bp_hold_valid got=%b exp=1", rsp_valid); end
      checks++; if (rsp_rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL bp_hold_rdata got=%h exp=deadbeef", rsp_rdata); end
      checks++; if (rsp_err !== 1'b0) begin failures++; $display("FAIL bp_hold_err got=%b exp=0", rsp_err); end
      checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL bp_hold_ready got=%b exp=0", req_ready); end
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL bp_release_valid got=%b exp=0", rsp_valid); end
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL bp_release_ready got=%b exp=1", req_ready); end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    k = 0;
    while (!rsp_valid && k < 50) begin @(negedge clk); k++; end
    checks++; if (k !== 3) begin failures++; $display("FAIL bp_next_latency got=%0d exp=3", k); end
    checks++; if (rsp_rdata !== 32'h11BB33DD) begin failures++; $display("FAIL bp_next_rdata got=%h exp=11bb33dd", rsp_rdata); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_wait;
    logic [31:0] d; logic e; int lat;
    do_req(1'b1, 32'h30, 32'h0, 4'hF, d, e, lat);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h30; req_wdata = 32'h55; req_be = 4'hF;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    checks++; if (fsm_state !== 2'd1) begin failures++; $display("FAIL mid_state_before got=%0d exp=1", fsm_state); end
    #2 reset = 1'b1;
    #1;
    checks++; if (fsm_state !== 2'd0) begin failures++; $display("FAIL mid_state_after got=%0d exp=0", fsm_state); end
    checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL mid_req_ready got=%b exp=0", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL mid_rsp_valid got=%b exp=0", rsp_valid); end
    checks++; if (rsp_rdata !== 32'h0) begin failures++; $display("FAIL mid_rsp_rdata got=%h exp=00000000", rsp_rdata); end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    do_req(1'b0, 32'h30, 32'h0, 4'h0, d, e, lat);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL mid_aborted_rdata got=%h exp=00000000", d); end
    checks++; if (e !== 1'b0) begin failures++; $display("FAIL mid_aborted_err got=%b exp=0", e); end
  endtask

  // Requests held valid with rsp_ready high: accept, ACCESS, RESP repeating.
  task automatic test_back_to_back;
    logic exp_rr, exp_rv;
    valid0 = 1'b1; write0 = 1'b1; addr0 = 32'h8; wdata0 = 32'hCAFE0001; be0 = 4'hF;
    for (int n = 0; n < 12; n++) begin
      exp_rr = ((n % 3) == 0);
      exp_rv = ((n % 3) == 2);
      checks++; if (ready0 !== exp_rr) begin failures++; $display("FAIL b2b_ready n=%0d got=%b exp=%b", n, ready0, exp_rr); end
      checks++; if (rv0 !== exp_rv) begin failures++; $display("FAIL b2b_valid n=%0d got=%b exp=%b", n, rv0, exp_rv); end
      if (exp_rv) begin
        checks++;
        if (rdata0 !== ((n == 2) ? 32'h0 : 32'hCAFE0001)) begin
          failures++; $display("FAIL b2b_rdata n=%0d got=%h exp=%h", n, rdata0, (n == 2) ? 32'h0 : 32'hCAFE0001);
        end
        checks++; if (err0 !== 1'b0) begin failures++; $display("FAIL b2b_err n=%0d got=%b exp=0", n, err0); end
      end
      if (n == 1) write0 = 1'b0;
      @(negedge clk);
    end
    valid0 = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_byte_lanes();
    test_errors();
    test_backpressure();
    test_reset_mid_wait();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
